eth_frame_rx: RTL and testbench
===============================

// Module: eth_frame_rx
// PURPOSE
//  RMII receive front end. Strips preamble/SFD and the 14-byte MAC header from the raw dibit stream.
//  Qualifies the frame by EtherType, and re-orders each payload byte from RMII LSB-first to MSB-first dibits.
//  Feeds the one's-complement checksum stage and the IPv4 parsers directly downstream.
//  axiov is asserted only while payload dibits are valid; its falling edge marks end of frame for consumers.
// PARAMETERS
//  MAC_ADDR      48'h69_69_5A_06_54_91  station address, byte 0 = MSBs, first on wire
//  ETHERTYPE     16'h0800               accepted EtherType (IPv4)
//  PREAMBLE_MIN  8                      min count of 2'b01 dibits before SFD; valid range 1..31
// PORTS
//  clk          in   1   50 MHz RMII reference clock
//  rst          in   1   asynchronous, active-high reset
//  axiiv        in   1   RMII CRS_DV
//  axiid        in   2   RMII RXD; bit0 is earlier on wire
//  axiov        out  1   payload dibit valid
//  axiod        out  2   payload dibit, MSB-first within each byte
//  frame_done   out  1   1-cycle pulse after the last payload dibit of an accepted frame
//  frame_drop   out  1   1-cycle pulse when a frame is rejected
// BEHAVIOUR
//  Reset: asynchronous on rst high. State=IDLE; all counters and byte registers cleared.
//   All outputs read 0 while rst is high and in the first cycle after release.
//  FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN, DROP.
//  IDLE: axiiv&&axiid==01 -> PREAMBLE (count=1). axiiv with any other value -> DROP.
//  PREAMBLE: 01 -> count++, saturating at 31.
//   11 with count>=PREAMBLE_MIN -> HEADER. 11 with count<PREAMBLE_MIN -> DROP.
//   00/10 -> DROP. axiiv low -> IDLE with no pulse.
//  HEADER: 56 dibits. Bytes assembled LSB-first: byte[2k+1:2k] = k-th dibit.
//   Bytes 0-5 = dst MAC, 12-13 = EtherType (byte 12 = high byte).
//   On dibit 55: EtherType==ETHERTYPE (and filter passes) -> PAYLOAD, else -> DROP.
//   axiiv low before dibit 55 -> IDLE with a frame_drop pulse.
//  PAYLOAD: collect 4 dibits into an input byte register.
//   On the 4th dibit, the byte moves to the output register (double-buffered).
//   Output register emits byte[7:6],[5:4],[3:2],[1:0] on the next 4 cycles with axiov=1.
//   Fixed latency: first output dibit appears 4 cycles after the first input dibit of its byte.
//   Continuous input yields continuous axiov.
//  End of frame: axiiv low in PAYLOAD -> DRAIN. A partial input byte (1-3 dibits) is discarded silently.
//   DRAIN finishes the output register (0-4 cycles). frame_done pulses the cycle after the last axiov=1.
//   Zero complete payload bytes still gives frame_done, asserted in the cycle after axiiv falls.
//   DRAIN -> IDLE together with the frame_done pulse.
//  DRAIN ignores axiiv. A preamble that starts during DRAIN is re-qualified from IDLE.
//   The SFD is still accepted once PREAMBLE_MIN dibits have been seen.
//  DROP: frame_drop pulses on entry, and on the early-HEADER exit above. axiov stays 0.
//   Exit to IDLE on the first cycle with axiiv low.
//  frame_done and frame_drop are never high in the same cycle. axiod=2'b00 whenever axiov=0.
//  FCS is not stripped; the 4 FCS bytes pass through as payload, and the consumer discards them.
// CONFIGURATION
//  ETH_DST_FILTER_EN defined: at header end, dst MAC must equal MAC_ADDR or 48'hFF_FF_FF_FF_FF_FF, else -> DROP.
//  ETH_DST_FILTER_EN undefined: dst MAC bytes are not stored; every dst is accepted and only EtherType qualifies.
// STRUCTURE
//  Package eth_rx_pkg holds:
//   - state enum
//   - PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11
//   - HDR_DIBITS=56, BCAST_MAC, ETHERTYPE_IPV4=16'h0800
//  Sub-module dibit_byte_flip: 4-dibit LSB-first assembler plus MSB-first re-serialiser.
//   Ports: clk, rst, in_valid, in_dibit, flush, out_valid, out_dibit, empty.
//   Used for the PAYLOAD/DRAIN datapath; the FSM and header capture stay in eth_frame_rx.
// TESTING
//  1 31x01+11, dst=MAC_ADDR, type 0800, payload 45 00 (wire dibits 01,01,00,01,00,00,00,00)
//     -> axiod 01,00,01,01,00,00,00,00 over 8 cycles, starting 4 cycles after the first payload dibit.
//     -> frame_done 1 cycle after the last output dibit.
//  2 Same frame with type 0806 -> axiov never 1; frame_drop pulses at the cycle after header dibit 55.
//  3 4x01 then 11 with PREAMBLE_MIN=8 -> frame_drop; no output. A following valid frame is accepted normally.
//  4 Payload 3 bytes + 2 dibits, then axiiv low -> exactly 12 output dibits; tail discarded; one frame_done.
//  5 rst pulsed mid-payload -> axiov=0 immediately, no frame_done. The next full frame reproduces test 1 exactly.
//  6 dst=00_11_22_33_44_56: with ETH_DST_FILTER_EN -> frame_drop; without -> accepted as in test 1.
//     Dst FF..FF is accepted in both builds.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive front end.
// Purely declarative: no logic, no latency, no flow control.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_DRAIN,
    S_DROP
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam int          HDR_DIBITS     = 56;
  localparam logic [47:0] BCAST_MAC      = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  // Header bytes are captured with byte 0 in the low byte; this puts a
  // station address (byte 0 = MSBs) into that same order for comparison.
  function automatic logic [47:0] mac_wire_order(input logic [47:0] mac);
    logic [47:0] w;
    w = '0;
    for (int b = 0; b < 6; b++) begin
      w[8*b +: 8] = mac[8*(5-b) +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dibit_byte_flip.sv
// Collects 4 LSB-first dibits into a byte, then replays it MSB-first from a second register.
// Latency 4 cycles from first input dibit to first output dibit; no backpressure, flush drops a partial byte.
module dibit_byte_flip (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_dibit,
  input  logic       flush,
  output logic       out_valid,
  output logic [1:0] out_dibit,
  output logic       empty
);

  logic [5:0] r_in_sr;
  logic [1:0] r_in_cnt;
  logic [7:0] r_out_sr;
  logic [2:0] r_out_cnt;
  logic       w_byte_done;

  // The 4th dibit is byte[7:6], so it goes straight into the output register.
  assign w_byte_done = in_valid && !flush && (r_in_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_sr   <= '0;
      r_in_cnt  <= '0;
      r_out_sr  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (flush) begin
        r_in_cnt <= '0;
      end else if (in_valid) begin
        r_in_cnt <= r_in_cnt + 2'd1;
        case (r_in_cnt)
          2'd0:    r_in_sr[1:0] <= in_dibit;
          2'd1:    r_in_sr[3:2] <= in_dibit;
          2'd2:    r_in_sr[5:4] <= in_dibit;
          default: ;
        endcase
      end

      if (w_byte_done) begin
        r_out_sr  <= {in_dibit, r_in_sr};
        r_out_cnt <= 3'd4;
      end else if (r_out_cnt != 3'd0) begin
        r_out_sr  <= {r_out_sr[5:0], 2'b00};
        r_out_cnt <= r_out_cnt - 3'd1;
      end
    end
  end

  assign empty     = (r_out_cnt == 3'd0);
  assign out_valid = !empty;
  assign out_dibit = out_valid ? r_out_sr[7:6] : 2'b00;

endmodule

// File: rtl/eth_frame_rx.sv
// RMII RX: strips preamble/SFD and MAC header, qualifies EtherType (plus dst MAC when ETH_DST_FILTER_EN is defined).
// Payload out 4 cycles after its first input dibit; no backpressure, rejected frames are dropped with a frame_drop pulse.
module eth_frame_rx
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE    = ETHERTYPE_IPV4,
  parameter int unsigned PREAMBLE_MIN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       frame_drop
);

  localparam logic [4:0] PRE_MIN  = 5'(PREAMBLE_MIN);
  localparam logic [5:0] HDR_LAST = 6'(HDR_DIBITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_pre_cnt;
  logic [4:0]  w_pre_cnt_nxt;
  logic [5:0]  r_hdr_cnt;
  logic [15:0] r_type_wire;
  logic [15:0] w_type_wire;
  logic [15:0] w_ethertype;
  logic        r_frame_drop;
  logic        w_drop_pulse;
  logic        w_type_ok;
  logic        w_dst_ok;
  logic        w_pay_vld;
  logic        w_flush;
  logic        w_empty;

  // Byte 12 is captured in the low byte; the last dibit of byte 13 is still on axiid.
  assign w_type_wire = {axiid, r_type_wire[13:0]};
  assign w_ethertype = {w_type_wire[7:0], w_type_wire[15:8]};
  assign w_type_ok   = (w_ethertype == ETHERTYPE);

`ifdef ETH_DST_FILTER_EN
  localparam logic [47:0] MAC_WIRE = mac_wire_order(MAC_ADDR);

  logic [47:0] r_dst_wire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_wire <= '0;
    end else if (r_state == S_HEADER && axiiv && r_hdr_cnt < 6'd24) begin
      r_dst_wire[{r_hdr_cnt[4:0], 1'b0} +: 2] <= axiid;
    end
  end

  assign w_dst_ok = (r_dst_wire == MAC_WIRE) || (r_dst_wire == BCAST_MAC);
`else
  logic w_unused_mac;

  assign w_unused_mac = ^MAC_ADDR;
  assign w_dst_ok     = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= '0;
      r_hdr_cnt    <= '0;
      r_type_wire  <= '0;
      r_frame_drop <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pre_cnt    <= w_pre_cnt_nxt;
      r_hdr_cnt    <= (r_state == S_HEADER && w_state_nxt == S_HEADER) ? r_hdr_cnt + 6'd1 : 6'd0;
      r_frame_drop <= w_drop_pulse;
      if (r_state == S_HEADER && axiiv && r_hdr_cnt[5:3] == 3'b110) begin
        r_type_wire[{r_hdr_cnt[2:0], 1'b0} +: 2] <= axiid;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_drop_pulse  = 1'b0;
    frame_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (axiiv) begin
          if (axiid == PREAMBLE_DIBIT) begin
            w_state_nxt   = S_PREAMBLE;
            w_pre_cnt_nxt = 5'd1;
          end else begin
            w_state_nxt  = S_DROP;
            w_drop_pulse = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!axiiv) begin
          w_state_nxt = S_IDLE;
        end else if (axiid == PREAMBLE_DIBIT) begin
          if (r_pre_cnt != 5'd31) begin
            w_pre_cnt_nxt = r_pre_cnt + 5'd1;
          end
        end else if (axiid == SFD_DIBIT && r_pre_cnt >= PRE_MIN) begin
          w_state_nxt = S_HEADER;
        end else begin
          w_state_nxt  = S_DROP;
          w_drop_pulse = 1'b1;
        end
      end
      S_HEADER: begin
        if (!axiiv) begin
          w_state_nxt  = S_IDLE;
          w_drop_pulse = 1'b1;
        end else if (r_hdr_cnt == HDR_LAST) begin
          if (w_type_ok && w_dst_ok) begin
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_state_nxt  = S_DROP;
            w_drop_pulse = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (!axiiv) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // axiiv is deliberately ignored until the output register has drained.
        if (w_empty) begin
          w_state_nxt = S_IDLE;
          frame_done  = 1'b1;
        end
      end
      S_DROP: begin
        if (!axiiv) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_pay_vld = (r_state == S_PAYLOAD) && axiiv;
  assign w_flush   = (r_state == S_PAYLOAD) && !axiiv;

  dibit_byte_flip u_flip (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_pay_vld),
    .in_dibit  (axiid),
    .flush     (w_flush),
    .out_valid (axiov),
    .out_dibit (axiod),
    .empty     (w_empty)
  );

  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed bench for eth_frame_rx: table of whole frames plus hand-written reset sequences.
module tb_eth_frame_rx;

  localparam logic [47:0] MAC   = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;

  logic       clk;
  logic       rst;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_done;
  logic       frame_drop;

  eth_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // drop_kind: 0 none, 1 pulse after SFD, 2 pulse after header dibit 55
  typedef struct {
    int          pre;
    logic [47:0] dst;
    logic [15:0] etype;
    int          nbytes;
    logic [31:0] pay;
    int          tail;
    int          exp_n;
    logic [31:0] exp_out;
    int          exp_done;
    int          exp_drop;
    int          drop_kind;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] out_q[$];
  int first_out, last_out, done_n, done_cyc, drop_n, drop_cyc;
  int first_pay, sfd_cyc, hdr55_cyc, fall_cyc;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_log();
    out_q.delete();
    first_out = -1; last_out = -1;
    done_n = 0; done_cyc = -1;
    drop_n = 0; drop_cyc = -1;
    first_pay = -1; sfd_cyc = -1; hdr55_cyc = -1; fall_cyc = -1;
  endtask

  // Sample outputs at the falling edge, then drive the next input.
  task automatic step(input logic v, input logic [1:0] d);
    @(negedge clk);
    if (axiov) begin
      out_q.push_back(axiod);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (frame_done) begin done_n++; done_cyc = cyc; end
    if (frame_drop) begin drop_n++; drop_cyc = cyc; end
    chk("axiod_zero_when_idle", longint'(axiov ? 2'b00 : axiod), 0);
    chk("done_drop_exclusive", longint'(frame_done & frame_drop), 0);
    axiiv = v;
    axiid = d;
    cyc++;
  endtask

  task automatic drive_pre(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 2'b01);
    sfd_cyc = cyc;
    step(1'b1, 2'b11);
  endtask

  task automatic drive_hdr(input logic [47:0] dst, input logic [15:0] etype);
    logic [7:0] hb;
    for (int j = 0; j < 14; j++) begin
      if (j < 6)       hb = dst[8*(5-j) +: 8];
      else if (j < 12) hb = SRC[8*(11-j) +: 8];
      else if (j == 12) hb = etype[15:8];
      else             hb = etype[7:0];
      for (int p = 0; p < 4; p++) begin
        if (j == 13 && p == 3) hdr55_cyc = cyc;
        step(1'b1, hb[2*p +: 2]);
      end
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    for (int p = 0; p < 4; p++) begin
      if (p == 0 && first_pay < 0) first_pay = cyc;
      step(1'b1, b[2*p +: 2]);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [31:0] got;
    v = vecs[i];
    clear_log();
    drive_pre(v.pre);
    drive_hdr(v.dst, v.etype);
    for (int b = 0; b < v.nbytes; b++) drive_byte(v.pay[31-8*b -: 8]);
    for (int t = 0; t < v.tail; t++) step(1'b1, 2'b10);
    fall_cyc = cyc;
    for (int k = 0; k < 12; k++) step(1'b0, 2'b00);

    got = '0;
    for (int k = 0; k < out_q.size() && k < 16; k++) got[31-2*k -: 2] = out_q[k];
    chk($sformatf("v%0d_out_dibits", i), out_q.size(), v.exp_n);
    chk($sformatf("v%0d_out_data", i), got, v.exp_out);
    chk($sformatf("v%0d_done_count", i), done_n, v.exp_done);
    chk($sformatf("v%0d_drop_count", i), drop_n, v.exp_drop);
    if (v.exp_n > 0) begin
      chk($sformatf("v%0d_first_latency", i), first_out - first_pay, 4);
      chk($sformatf("v%0d_contiguous", i), last_out - first_out + 1, v.exp_n);
    end
    if (v.exp_done > 0) begin
      if (v.exp_n > 0) chk($sformatf("v%0d_done_after_last", i), done_cyc - last_out, 1);
      else             chk($sformatf("v%0d_done_after_fall", i), done_cyc - fall_cyc, 1);
    end
    if (v.drop_kind == 1) chk($sformatf("v%0d_drop_after_sfd", i), drop_cyc - sfd_cyc, 1);
    if (v.drop_kind == 2) chk($sformatf("v%0d_drop_after_hdr", i), drop_cyc - hdr55_cyc, 1);
  endtask

  logic [1:0] t1_exp[8];

  initial begin
    vecs[0] = '{31, MAC, 16'h0800, 2, 32'h4500_0000, 0, 8, 32'h4500_0000, 1, 0, 0};
    vecs[1] = '{31, MAC, 16'h0806, 2, 32'h4500_0000, 0, 0, 32'h0, 0, 1, 2};
    vecs[2] = '{4, MAC, 16'h0800, 2, 32'h4500_0000, 0, 0, 32'h0, 0, 1, 1};
    vecs[3] = '{8, MAC, 16'h0800, 3, 32'hA53C_0F00, 2, 12, 32'hA53C_0F00, 1, 0, 0};
    vecs[4] = '{8, BCAST, 16'h0800, 1, 32'hE400_0000, 0, 4, 32'hE400_0000, 1, 0, 0};
    vecs[5] = '{7, MAC, 16'h0800, 1, 32'hE400_0000, 0, 0, 32'h0, 0, 1, 1};
    vecs[6] = '{31, 48'h00_11_22_33_44_56, 16'h0800, 2, 32'h4500_0000, 0, 8, 32'h4500_0000, 1, 0, 0};
    vecs[7] = '{10, MAC, 16'h0800, 0, 32'h0, 3, 0, 32'h0, 1, 0, 0};
    vecs[8] = '{40, MAC, 16'h0800, 4, 32'h1234_5678, 0, 16, 32'h1234_5678, 1, 0, 0};
`ifdef ETH_DST_FILTER_EN
    vecs[6].exp_n     = 0;
    vecs[6].exp_out   = 32'h0;
    vecs[6].exp_done  = 0;
    vecs[6].exp_drop  = 1;
    vecs[6].drop_kind = 2;
`endif
    t1_exp = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    rst = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_axiov", axiov, 0);
    chk("rst_axiod", axiod, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_drop", frame_drop, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_axiov", axiov, 0);
    chk("post_rst_done", frame_done, 0);
    chk("post_rst_drop", frame_drop, 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset in the middle of payload output.
    clear_log();
    drive_pre(31);
    drive_hdr(MAC, 16'h0800);
    drive_byte(8'h45);
    drive_byte(8'h00);
    @(negedge clk);
    chk("midrst_axiov_before", axiov, 1);
    rst = 1'b1;
    axiiv = 1'b0;
    #1;
    chk("midrst_axiov_immediate", axiov, 0);
    clear_log();
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    rst = 1'b0;
    step(1'b0, 2'b00);
    chk("midrst_release_axiov", axiov, 0);
    chk("midrst_release_done", frame_done, 0);
    chk("midrst_release_drop", frame_drop, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b00);
    chk("midrst_no_done", done_n, 0);
    chk("midrst_no_drop", drop_n, 0);
    chk("midrst_no_output", out_q.size(), 0);

    run_vec(0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rerun_dibit%0d", i),
          (i < out_q.size()) ? longint'(out_q[i]) : -1, longint'(t1_exp[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
